// File: rtl/ab_pkg.sv
// Shared encodings for the 65C24T8 address-bus generator.
package ab_pkg;

  localparam int unsigned AB_OP_W   = 11;
  localparam int unsigned BYTE_W    = 8;

  // ab_op field positions
  localparam int unsigned OP_CI     = 0;
  localparam int unsigned OP_OFS_LO = 1;
  localparam int unsigned OP_BS_LO  = 3;
  localparam int unsigned OP_HOLD   = 7;
  localparam int unsigned OP_H_LO   = 8;
  localparam int unsigned OP_PX     = 10;

  typedef enum logic [1:0] {
    BS_STACK = 2'b00,
    BS_PC    = 2'b01,
    BS_DATA  = 2'b10,
    BS_HOLD  = 2'b11
  } base_sel_e;

  typedef enum logic [1:0] {
    OFS_0    = 2'b00,
    OFS_XY   = 2'b01,
    OFS_DI   = 2'b10,
    OFS_XYDI = 2'b11
  } ofs_sel_e;

  typedef enum logic [1:0] {
    H_0    = 2'b00,
    H_1    = 2'b01,
    H_C    = 2'b10,
    H_BACK = 2'b11
  } h_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FIX  = 1'b1
  } state_e;

endpackage

// File: rtl/ab_gen_px_byte_add.sv
// One address byte: 8-bit add with carry in/out.
module ab_byte_add (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] sum,
  output logic       co
);

  // Ripple-free 9-bit add; the top bit is the byte carry out
  assign {co, sum} = 9'(a) + 9'(b) + 9'(ci);

endmodule

// File: rtl/ab_gen_px.sv
// Address-bus generator: base + index with per-byte carry control and a
// one-cycle page-cross fixup that presents the uncorrected address first.
module ab_gen_px
  import ab_pkg::*;
#(
  parameter int unsigned   AW      = 24,
  parameter logic [AW-1:0] RST_VEC = {AW{1'b1}}
) (
  input  logic                               clk,
  input  logic                               RST_N,
  input  logic                               RDY,
  input  logic [AB_OP_W-1:0]                 ab_op,
  input  logic [2:0]                         T,
  input  logic [7:0]                         S,
  input  logic [7:0]                         DI,
  input  logic [7:0]                         DR,
  input  logic [((AW > 16) ? AW-17 : 0):0]   DU,
  input  logic [7:0]                         XY,
  input  logic                               ABWDTH,
  input  logic [AW-1:0]                      PCT,
  output logic [AW-1:0]                      AB,
  output logic                               STALL,
  output logic                               FIX
);

  localparam int unsigned NB = AW / BYTE_W;

  base_sel_e     bs_sel;
  ofs_sel_e      ofs_sel;
  h_mode_e       h_mode;
  logic          ci;
  logic          hold_en;
  logic          px_en;

  logic [AW-1:0] base;
  logic [AW-1:0] ab_hold;
  logic [AW-1:0] fix_ab;
  logic          fix_hold;
  logic [AW-1:0] ab_full;
  logic [AW-1:0] ab_dummy;
  logic [7:0]    lo_a;
  logic [7:0]    lo_b;
  logic [7:0]    lo_sum;
  logic          abl_co;
  logic [7:0]    h_b;
  logic [7:0]    up_b;
  logic          px_hit;

  state_e        state_q;
  state_e        state_d;
  logic [AW-1:0] ab_nxt;
  logic          stall;
  logic          fix;
  logic          load_fix;
  logic          capture;

  assign ci      = ab_op[OP_CI];
  assign ofs_sel = ofs_sel_e'(ab_op[OP_OFS_LO +: 2]);
  assign bs_sel  = base_sel_e'(ab_op[OP_BS_LO +: 2]);
  assign h_mode  = h_mode_e'(ab_op[OP_H_LO +: 2]);
  assign hold_en = ab_op[OP_HOLD];
  assign px_en   = ab_op[OP_PX];

  // Base address select
  always_comb begin
    base = ab_hold;
    unique case (bs_sel)
      BS_STACK: base = AW'({T, S});
      BS_PC:    base = PCT;
      BS_DATA:  base = ABWDTH ? AW'({DU, DI, DR}) : AW'({DI, DR});
      default:  base = ab_hold;
    endcase
  end

  // Low-byte operand select; OFS_XYDI bypasses the base entirely
  always_comb begin
    lo_a = base[7:0];
    lo_b = 8'h00;
    unique case (ofs_sel)
      OFS_0:    begin lo_a = base[7:0]; lo_b = 8'h00; end
      OFS_XY:   begin lo_a = base[7:0]; lo_b = XY;    end
      OFS_DI:   begin lo_a = base[7:0]; lo_b = DI;    end
      default:  begin lo_a = XY;        lo_b = DI;    end
    endcase
  end

  // Byte-1 addend and upper-byte addend (all-ones on the borrow path)
  always_comb begin
    h_b = 8'h00;
    unique case (h_mode)
      H_1:     h_b = 8'h01;
      H_BACK:  h_b = 8'hFF;
      default: h_b = 8'h00;
    endcase
    up_b = (ABWDTH && h_mode == H_BACK) ? 8'hFF : 8'h00;
  end

  ab_byte_add u_lo (
    .a   (lo_a),
    .b   (lo_b),
    .ci  (ci),
    .sum (lo_sum),
    .co  (abl_co)
  );

  assign ab_full[7:0]  = lo_sum;
  assign ab_dummy[7:0] = lo_sum;

  // Two carry chains: corrected sum and dummy sum with the low carry dropped
  for (genvar i = 1; i < NB; i++) begin : g_byte
    logic [7:0] b_op;
    logic       ci_f;
    logic       ci_d;
    logic       co_f;
    logic       co_d;
    if (i == 1) begin : g_h
      assign b_op = h_b;
      assign ci_f = h_mode[1] & abl_co;
      assign ci_d = 1'b0;
    end else begin : g_u
      assign b_op = up_b;
      assign ci_f = ABWDTH & g_byte[i-1].co_f;
      assign ci_d = ABWDTH & g_byte[i-1].co_d;
    end
    ab_byte_add u_full (
      .a   (base[8*i +: 8]),
      .b   (b_op),
      .ci  (ci_f),
      .sum (ab_full[8*i +: 8]),
      .co  (co_f)
    );
    ab_byte_add u_dummy (
      .a   (base[8*i +: 8]),
      .b   (b_op),
      .ci  (ci_d),
      .sum (ab_dummy[8*i +: 8]),
      .co  (co_d)
    );
  end

  logic unused_ok;
  assign unused_ok = ^{ab_op[6:5], g_byte[NB-1].co_f, g_byte[NB-1].co_d};

  assign px_hit = px_en & ab_op[9] & abl_co;

  // FSM state register; RDY low freezes the sequence
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else if (RDY) begin
      state_q <= state_d;
    end
  end

  // Next state and bus outputs
  always_comb begin
    state_d  = state_q;
    ab_nxt   = ab_full;
    stall    = 1'b0;
    fix      = 1'b0;
    load_fix = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (px_hit) begin
          ab_nxt   = ab_dummy;
          stall    = 1'b1;
          load_fix = 1'b1;
          state_d  = ST_FIX;
        end else begin
          capture  = hold_en;
        end
      end
      default: begin
        ab_nxt  = fix_ab;
        fix     = 1'b1;
        capture = fix_hold;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset overrides the bus immediately, independent of the inputs
  assign AB    = RST_N ? ab_nxt : RST_VEC;
  assign STALL = RST_N & stall;
  assign FIX   = RST_N & fix;

  // Corrected-address and hold registers
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      ab_hold  <= RST_VEC;
      fix_ab   <= '0;
      fix_hold <= 1'b0;
    end else if (RDY) begin
      if (load_fix) begin
        fix_ab   <= ab_full;
        fix_hold <= hold_en;
      end
      if (capture) begin
        ab_hold <= ab_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ab_gen_px.sv
// Directed bench for ab_gen_px (AW=24): vector table plus multi-cycle sequences.
module tb_ab_gen_px;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic [10:0] ab_op;
  logic [2:0]  t;
  logic [7:0]  s, di, dr, du, xy;
  logic        abwdth;
  logic [23:0] pct;
  logic [23:0] ab;
  logic        stall;
  logic        fix;

  int checks = 0;
  int errors = 0;

  ab_gen_px #(.AW(24)) dut (
    .clk    (clk),
    .RST_N  (rst_n),
    .RDY    (rdy),
    .ab_op  (ab_op),
    .T      (t),
    .S      (s),
    .DI     (di),
    .DR     (dr),
    .DU     (du),
    .XY     (xy),
    .ABWDTH (abwdth),
    .PCT    (pct),
    .AB     (ab),
    .STALL  (stall),
    .FIX    (fix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [10:0] op;
    logic [2:0]  t;
    logic [7:0]  s, di, dr, du, xy;
    logic        w;
    logic [23:0] pct;
    logic [23:0] exp_ab;
  } vec_t;

  function automatic logic [10:0] mk_op(input logic px, input logic [1:0] h, input logic hold,
                                        input logic [1:0] bs, input logic [1:0] ofs, input logic c);
    return {px, h, hold, 2'b00, bs, ofs, c};
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [10:0] op, input logic [2:0] tt, input logic [7:0] ss,
                       input logic [7:0] d_i, input logic [7:0] d_r, input logic [7:0] d_u,
                       input logic [7:0] x, input logic w, input logic [23:0] pc);
    ab_op = op; t = tt; s = ss; di = d_i; dr = d_r; du = d_u; xy = x; abwdth = w; pct = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  vec_t vecs[14];

  initial begin
    // name, op(px,h,hold,bs,ofs,ci), T, S, DI, DR, DU, XY, W, PCT, expected AB
    vecs[0]  = '{"stack",      mk_op(0,2'b00,0,2'b00,2'b00,0), 3'h1, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 24'h000000, 24'h0001FD};
    vecs[1]  = '{"stack_wrap", mk_op(0,2'b00,0,2'b00,2'b00,1), 3'h1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 24'h000000, 24'h000100};
    vecs[2]  = '{"stack_cy",   mk_op(0,2'b10,0,2'b00,2'b00,1), 3'h1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 24'h000000, 24'h000200};
    vecs[3]  = '{"pc",         mk_op(0,2'b00,0,2'b01,2'b00,0), 3'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 24'hABCDEF, 24'hABCDEF};
    vecs[4]  = '{"pc_h1",      mk_op(0,2'b01,0,2'b01,2'b00,0), 3'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 24'hABCDEF, 24'hABCEEF};
    vecs[5]  = '{"data16",     mk_op(0,2'b10,0,2'b10,2'b01,0), 3'h0, 8'h00, 8'h12, 8'hF0, 8'h34, 8'h05, 1'b0, 24'h000000, 24'h0012F5};
    vecs[6]  = '{"data24",     mk_op(1,2'b10,0,2'b10,2'b01,0), 3'h0, 8'h00, 8'h12, 8'hF0, 8'h34, 8'h05, 1'b1, 24'h000000, 24'h3412F5};
    vecs[7]  = '{"ofs_di",     mk_op(0,2'b10,0,2'b01,2'b10,0), 3'h0, 8'h00, 8'h90, 8'h00, 8'h00, 8'h00, 1'b1, 24'h001080, 24'h001110};
    vecs[8]  = '{"ofs_xydi",   mk_op(0,2'b10,0,2'b01,2'b11,1), 3'h0, 8'h00, 8'h40, 8'h00, 8'h00, 8'h30, 1'b1, 24'h5566AA, 24'h556671};
    vecs[9]  = '{"wrap16",     mk_op(0,2'b10,0,2'b01,2'b00,1), 3'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 24'h12FFFF, 24'h120000};
    vecs[10] = '{"wrap24",     mk_op(0,2'b10,0,2'b01,2'b00,1), 3'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 24'h12FFFF, 24'h130000};
    vecs[11] = '{"px_nostall", mk_op(1,2'b01,0,2'b01,2'b01,0), 3'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 1'b1, 24'h0020F0, 24'h002110};
    vecs[12] = '{"back24",     mk_op(0,2'b11,0,2'b01,2'b00,0), 3'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 24'h120000, 24'h11FF00};
    vecs[13] = '{"back_cy",    mk_op(0,2'b11,0,2'b01,2'b01,0), 3'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 1'b1, 24'h123480, 24'h123400};

    rdy = 1'b1;
    rst_n = 1'b0;
    // Page-cross inputs present during reset: outputs must still show reset values
    drive(mk_op(1,2'b10,0,2'b10,2'b01,0), 3'h0, 8'h00, 8'h12, 8'hF0, 8'h34, 8'h20, 1'b1, 24'h0);
    #12;
    chk("rst_ab", ab, 24'hFFFFFF);
    chk("rst_stall", 24'(stall), 24'h0);
    chk("rst_fix", 24'(fix), 24'h0);
    drive(mk_op(0,2'b00,0,2'b11,2'b00,0), 3'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("hold_rst_vec", ab, 24'hFFFFFF);

    // Single-cycle table
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].t, vecs[i].s, vecs[i].di, vecs[i].dr, vecs[i].du,
            vecs[i].xy, vecs[i].w, vecs[i].pct);
      settle();
      chk({vecs[i].name, "_ab"}, ab, vecs[i].exp_ab);
      chk({vecs[i].name, "_stall"}, 24'(stall), 24'h0);
      chk({vecs[i].name, "_fix"}, 24'(fix), 24'h0);
      step();
    end

    // Page-cross, back-to-back, inputs ignored during FIX
    drive(mk_op(1,2'b10,0,2'b10,2'b01,0), 3'h0, 8'h00, 8'h12, 8'hF0, 8'h34, 8'h20, 1'b1, 24'h0);
    settle();
    chk("px0_ab", ab, 24'h341210);
    chk("px0_stall", 24'(stall), 24'h1);
    chk("px0_fix", 24'(fix), 24'h0);
    step();
    chk("px1_ab", ab, 24'h341310);
    chk("px1_fix", 24'(fix), 24'h1);
    chk("px1_stall", 24'(stall), 24'h0);
    xy = 8'h00;
    settle();
    chk("px1_ignore", ab, 24'h341310);
    xy = 8'h20;
    step();
    chk("px2_ab", ab, 24'h341210);
    chk("px2_stall", 24'(stall), 24'h1);
    step();
    chk("px3_ab", ab, 24'h341310);
    chk("px3_fix", 24'(fix), 24'h1);
    step();

    // Wait states during page-cross with hold capture
    rdy = 1'b0;
    drive(mk_op(1,2'b10,1,2'b10,2'b01,0), 3'h0, 8'h00, 8'h12, 8'hF0, 8'h34, 8'h20, 1'b1, 24'h0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ws_ab", ab, 24'h341210);
      chk("ws_stall", 24'(stall), 24'h1);
      step();
    end
    rdy = 1'b1;
    settle();
    chk("ws_rdy_stall", 24'(stall), 24'h1);
    step();
    chk("ws_fix_ab", ab, 24'h341310);
    chk("ws_fix", 24'(fix), 24'h1);
    step();
    drive(mk_op(0,2'b00,0,2'b11,2'b00,0), 3'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 24'h0);
    settle();
    chk("hold_corrected", ab, 24'h341310);
    step();

    // Back borrow from a captured hold value
    drive(mk_op(0,2'b00,1,2'b01,2'b00,0), 3'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 24'h010000);
    step();
    drive(mk_op(0,2'b11,0,2'b11,2'b00,0), 3'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 24'h0);
    settle();
    chk("back_borrow", ab, 24'h00FF00);
    step();

    // Reset asserted in the middle of a FIX cycle
    drive(mk_op(1,2'b10,0,2'b10,2'b01,0), 3'h0, 8'h00, 8'h12, 8'hF0, 8'h34, 8'h20, 1'b1, 24'h0);
    step();
    chk("pre_rst_fix", 24'(fix), 24'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midfix_ab", ab, 24'hFFFFFF);
    chk("midfix_fix", 24'(fix), 24'h0);
    chk("midfix_stall", 24'(stall), 24'h0);
    drive(mk_op(0,2'b00,0,2'b11,2'b00,0), 3'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_hold", ab, 24'hFFFFFF);
    chk("post_rst_fix", 24'(fix), 24'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
